// File: rtl/fifo8x64_slot_buffer_pkg.sv
// Shared widths for the 8x64 slot buffer and its register bank.
package fifo_defs;

  localparam int unsigned FIFO_DATA_W = 64;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned FIFO_AW     = 3;
  localparam int unsigned FIFO_CNT_W  = 4;

  // Advance a slot pointer; DEPTH is a power of two so the wrap is free.
  function automatic logic [FIFO_AW-1:0] ptr_inc(input logic [FIFO_AW-1:0] p);
    return p + FIFO_AW'(1);
  endfunction

endpackage

// File: rtl/fifo8x64_slot_buffer_regbank.sv
// fifo8x64_regbank: 8 x 64-bit slot registers, one write port, one
// combinational read port and all slots exposed flattened.
//   clk, reset_n      : clock, async active-low reset (slots clear to 0)
//   we, waddr, wdata  : write port
//   raddr, rdata      : combinational read port
//   slots_flat        : slot k at [64k+63:64k]
module fifo8x64_regbank
  import fifo_defs::*;
(
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              we,
  input  logic [FIFO_AW-1:0]                waddr,
  input  logic [FIFO_DATA_W-1:0]            wdata,
  input  logic [FIFO_AW-1:0]                raddr,
  output logic [FIFO_DATA_W-1:0]            rdata,
  output logic [FIFO_DATA_W*FIFO_DEPTH-1:0] slots_flat
);

  logic [FIFO_DATA_W-1:0] slot_q [FIFO_DEPTH];
  logic [FIFO_DATA_W-1:0] slot_d [FIFO_DEPTH];

  // Write-port update of the addressed slot.
  always_comb begin
    slot_d = slot_q;
    if (we) slot_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(FIFO_DEPTH); k++) slot_q[k] <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign rdata = slot_q[raddr];

  for (genvar g = 0; g < int'(FIFO_DEPTH); g++) begin : g_flat
    assign slots_flat[g*FIFO_DATA_W +: FIFO_DATA_W] = slot_q[g];
  end

endmodule

// File: rtl/fifo8x64_slot_buffer.sv
// fifo8x64_slot_buffer: 8-entry x 64-bit circular FIFO feeding an external
// 8:1 read-select mux, with its own registered pop port.
//   clk, reset_n            : clock, async active-low reset
//   flush                   : synchronous clear of pointers and count
//   wr_en/wr_data/wr_ready  : push port (accepted iff wr_en && wr_ready)
//   rd_en/rd_ready          : pop request (accepted iff rd_en && rd_ready)
//   rd_data/rd_valid        : registered popped word, one-cycle valid pulse
//   slot_data/rd_ptr/head_valid : mux data, select and enable
//   count/full/empty        : occupancy and decoded flags
//   overflow/underflow      : one-cycle error pulses
module fifo8x64_slot_buffer
  import fifo_defs::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_ready,
  input  logic                    rd_en,
  output logic                    rd_ready,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic [DATA_W*DEPTH-1:0] slot_data,
  output logic [FIFO_AW-1:0]      rd_ptr,
  output logic                    head_valid,
  output logic [FIFO_CNT_W-1:0]   count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned AW    = FIFO_AW;
  localparam int unsigned CNT_W = FIFO_CNT_W;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              push_ok, pop_ok;
  logic [DATA_W-1:0] head_word;

  // Flags decode from registered count only, so no request-to-output path.
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign wr_ready   = !full;
  assign rd_ready   = !empty;
  assign head_valid = !empty;

  // Flush wins over both requests; full blocks push even if a pop frees a slot.
  assign push_ok = wr_en && !full  && !flush;
  assign pop_ok  = rd_en && !empty && !flush;

  fifo8x64_regbank u_regbank (
    .clk        (clk),
    .reset_n    (reset_n),
    .we         (push_ok),
    .waddr      (wr_ptr_q),
    .wdata      (wr_data),
    .raddr      (rd_ptr_q),
    .rdata      (head_word),
    .slots_flat (slot_data)
  );

  // Next-state for pointers, count and the registered pop port.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = pop_ok;
    overflow_d  = wr_en && full  && !flush;
    underflow_d = rd_en && empty && !flush;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok) begin
        rd_ptr_d  = ptr_inc(rd_ptr_q);
        rd_data_d = head_word;
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_ptr    = rd_ptr_q;
  assign count     = count_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo8x64_slot_buffer.sv
// Scoreboard bench for fifo8x64_slot_buffer: a queue-based FIFO model
// predicts pops, flags and slot contents; a monitor checks popped words.
module tb_fifo8x64_slot_buffer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush, wr_en, rd_en;
  logic [63:0]  wr_data;
  logic         wr_ready, rd_ready, rd_valid, head_valid;
  logic         full, empty, overflow, underflow;
  logic [63:0]  rd_data;
  logic [511:0] slot_data;
  logic [2:0]   rd_ptr;
  logic [3:0]   count;

  fifo8x64_slot_buffer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .slot_data  (slot_data),
    .rd_ptr     (rd_ptr),
    .head_valid (head_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO contents as a queue, slot memory as an array,
  // pointers as running push/pop totals modulo 8.
  logic [63:0] fq[$];
  logic [63:0] exp_q[$];
  logic [63:0] mem [8];
  int          n_push, n_pop;
  logic [63:0] m_rd_data;
  logic        e_rdv, e_ovf, e_unf;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    exp_q.delete();
    for (int k = 0; k < 8; k++) mem[k] = '0;
    n_push = 0; n_pop = 0;
    m_rd_data = '0;
    e_rdv = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
  endtask

  task automatic check_state();
    logic [511:0] flat;
    int           c;
    c = fq.size();
    for (int k = 0; k < 8; k++) flat[k*64 +: 64] = mem[k];
    chk("count",      512'(count),      512'(c));
    chk("full",       512'(full),       512'(c == 8));
    chk("empty",      512'(empty),      512'(c == 0));
    chk("wr_ready",   512'(wr_ready),   512'(c != 8));
    chk("rd_ready",   512'(rd_ready),   512'(c != 0));
    chk("head_valid", 512'(head_valid), 512'(c != 0));
    chk("rd_ptr",     512'(rd_ptr),     512'(n_pop % 8));
    chk("slot_data",  slot_data,        flat);
    chk("rd_data",    512'(rd_data),    512'(m_rd_data));
    chk("rd_valid",   512'(rd_valid),   512'(e_rdv));
    chk("overflow",   512'(overflow),   512'(e_ovf));
    chk("underflow",  512'(underflow),  512'(e_unf));
    if (c != 0) chk("peek", 512'(slot_data[64*rd_ptr +: 64]), 512'(fq[0]));
  endtask

  // One clock: check state, drive inputs, predict the edge, advance to next negedge.
  task automatic cycle(input logic we, input logic [63:0] wd, input logic re, input logic fl);
    int  c;
    logic push, pop;
    check_state();
    wr_en = we; wr_data = wd; rd_en = re; flush = fl;
    c = fq.size();
    if (fl) begin
      e_rdv = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
      fq.delete();
      n_push = 0; n_pop = 0;
    end else begin
      push  = we && (c < 8);
      pop   = re && (c > 0);
      e_ovf = we && (c == 8);
      e_unf = re && (c == 0);
      e_rdv = pop;
      if (pop) begin
        m_rd_data = fq.pop_front();
        exp_q.push_back(m_rd_data);
        n_pop++;
      end
      if (push) begin
        fq.push_back(wd);
        mem[n_push % 8] = wd;
        n_push++;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every rd_valid must match the oldest predicted pop.
  always @(posedge clk) begin
    #1;
    if (reset_n === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL pop_unexpected: got %0h expected none", rd_data);
      end else begin
        chk("pop_data", 512'(rd_data), 512'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state();
    reset_n = 1'b1;

    // Fill to full with known words, then drain in order.
    for (int k = 1; k <= 8; k++) cycle(1'b1, 64'h1111_0000_0000_0000 | 64'(k), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Full with simultaneous push/pop: pop wins, push dropped, overflow.
    for (int k = 0; k < 8; k++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
    cycle(1'b1, 64'hDEAD, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Empty with simultaneous push/pop: push wins, underflow, then peek.
    for (int k = 0; k < 7; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 64'hBEEF, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // count=3 at rd_ptr=5, then 10 cycles of push+pop with wrap.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cycle(1'b1, rnd64(), 1'b1, 1'b0);

    // count=5, flush with both requests active.
    for (int k = 0; k < 2; k++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
    cycle(1'b1, rnd64(), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Randomised traffic with occasional flush.
    for (int k = 0; k < 400; k++)
      cycle(1'($urandom_range(0, 99) < 55), rnd64(), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 3));

    // Asynchronous reset between clock edges with traffic in flight.
    for (int k = 0; k < 4; k++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
    check_state();
    wr_en = 1'b1; wr_data = rnd64(); rd_en = 1'b1; flush = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_state();
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check_state();
    reset_n = 1'b1;
    for (int k = 0; k < 60; k++)
      cycle(1'($urandom_range(0, 1)), rnd64(), 1'($urandom_range(0, 1)), 1'b0);
    for (int k = 0; k < 9; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_state();
    chk("scoreboard_drained", 512'(exp_q.size()), 512'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
